// File: rtl/demux_1n_striper.sv
// demux_1n_striper: parametrised 1:N word demultiplexer for the lane datapath.
// Consecutive valid words are distributed round-robin over NUM_LANES lanes.
// GATHER=0 releases each word on its own lane one cycle after it arrives.
// GATHER=1 stages words and releases a whole (or flushed partial) lane group.
module demux_1n_striper #(
  parameter int DATA_W    = 8,
  parameter int NUM_LANES = 4,
  parameter int GATHER    = 1,
  localparam int LANE_W   = ($clog2(NUM_LANES) < 1) ? 1 : $clog2(NUM_LANES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  input  logic                          flush,
  output logic [NUM_LANES*DATA_W-1:0]   out_data,
  output logic [NUM_LANES-1:0]          out_valid,
  output logic [LANE_W-1:0]             lane_ptr,
  output logic [15:0]                   grp_cnt
);

  // Fill count must be able to represent a complete group (NUM_LANES words).
  localparam int CNT_W = LANE_W + 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  generate
    if (NUM_LANES < 2 || NUM_LANES > 16) begin : g_bad_lanes
      $error("demux_1n_striper: NUM_LANES must be in 2..16");
    end
    if (GATHER != 0 && GATHER != 1) begin : g_bad_mode
      $error("demux_1n_striper: GATHER must be 0 or 1");
    end
  endgenerate

  // Holding buffer for GATHER=1; lanes at or above lane_ptr are always zero.
  logic [NUM_LANES*DATA_W-1:0] hold_p0;

  logic [NUM_LANES*DATA_W-1:0] hold_nxt;
  logic [NUM_LANES*DATA_W-1:0] data_nxt;
  logic [NUM_LANES-1:0]        vld_nxt;
  logic [LANE_W-1:0]           ptr_nxt;
  logic [CNT_W-1:0]            fill;
  logic [NUM_LANES-1:0]        fill_mask;
  logic                        emit;

  // Next-state for pointer, buffer and output lanes (both modes).
  always_comb begin
    hold_nxt  = hold_p0;
    data_nxt  = out_data;
    vld_nxt   = '0;
    ptr_nxt   = lane_ptr;
    fill      = {1'b0, lane_ptr};
    fill_mask = '0;
    emit      = 1'b0;

    // Absorb the incoming word into the current lane and advance the pointer.
    if (in_valid) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (lane_ptr == LANE_W'(i)) begin
          hold_nxt[i*DATA_W +: DATA_W] = in_data;
        end
      end
      fill    = fill + CNT_W'(1);
      ptr_nxt = (lane_ptr == LAST_LANE) ? '0 : lane_ptr + LANE_W'(1);
    end

    // Lanes 0..fill-1 hold real words once the current word is absorbed.
    for (int i = 0; i < NUM_LANES; i++) begin
      fill_mask[i] = (CNT_W'(i) < fill);
    end

    if (GATHER == 0) begin
      // Stripe mode: update just the addressed lane, other lanes hold.
      hold_nxt = '0;
      if (in_valid) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (lane_ptr == LANE_W'(i)) begin
            data_nxt[i*DATA_W +: DATA_W] = in_data;
            vld_nxt[i]                   = 1'b1;
          end
        end
        emit = (lane_ptr == LAST_LANE);
      end
    end else begin
      // Gather mode: a completed group always wins; flush only adds a
      // partial release when something has been staged.
      emit = (in_valid && (lane_ptr == LAST_LANE)) ||
             (flush && (fill != '0));
      if (emit) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          data_nxt[i*DATA_W +: DATA_W] =
            fill_mask[i] ? hold_nxt[i*DATA_W +: DATA_W] : '0;
        end
        vld_nxt  = fill_mask;
        hold_nxt = '0;
        ptr_nxt  = '0;
      end
    end
  end

  // Output register stage: lanes, per-lane valid, pointer and group count.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= '0;
      lane_ptr  <= '0;
      grp_cnt   <= '0;
      hold_p0   <= '0;
    end else begin
      out_data  <= data_nxt;
      out_valid <= vld_nxt;
      lane_ptr  <= ptr_nxt;
      grp_cnt   <= grp_cnt + 16'(emit);
      hold_p0   <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_demux_1n_striper.sv
// Testbench for demux_1n_striper: three instances (gather N=4, stripe N=4,
// gather N=3) driven from vector tables through a scoreboard queue, plus a
// hand-written reset-during-staging sequence.
module tb_demux_1n_striper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  d1, d0, d3;
  logic        v1, v0, v3, f1, f0, f3;
  logic [31:0] od1, od0;
  logic [23:0] od3;
  logic [3:0]  ov1, ov0;
  logic [2:0]  ov3;
  logic [1:0]  lp1, lp0, lp3;
  logic [15:0] gc1, gc0, gc3;

  demux_1n_striper #(.DATA_W(8), .NUM_LANES(4), .GATHER(1)) u_g1 (
    .clk(clk), .reset(reset), .in_data(d1), .in_valid(v1), .flush(f1),
    .out_data(od1), .out_valid(ov1), .lane_ptr(lp1), .grp_cnt(gc1));

  demux_1n_striper #(.DATA_W(8), .NUM_LANES(4), .GATHER(0)) u_g0 (
    .clk(clk), .reset(reset), .in_data(d0), .in_valid(v0), .flush(f0),
    .out_data(od0), .out_valid(ov0), .lane_ptr(lp0), .grp_cnt(gc0));

  demux_1n_striper #(.DATA_W(8), .NUM_LANES(3), .GATHER(1)) u_g3 (
    .clk(clk), .reset(reset), .in_data(d3), .in_valid(v3), .flush(f3),
    .out_data(od3), .out_valid(ov3), .lane_ptr(lp3), .grp_cnt(gc3));

  typedef struct {
    bit          v;
    bit          f;
    logic [7:0]  d;
    logic [3:0]  ev;
    logic [31:0] ed;
    logic [1:0]  ep;
    logic [15:0] eg;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input bit v, input bit f, input logic [7:0] d,
                     input logic [3:0] ev, input logic [31:0] ed,
                     input logic [1:0] ep, input logic [15:0] eg);
    vec_t e;
    e.v = v; e.f = f; e.d = d; e.ev = ev; e.ed = ed; e.ep = ep; e.eg = eg;
    tbl.push_back(e);
  endtask

  task automatic drive(input int dut, input bit v, input bit f,
                       input logic [7:0] d);
    case (dut)
      0:       begin v0 = v; f0 = f; d0 = d; end
      1:       begin v1 = v; f1 = f; d1 = d; end
      default: begin v3 = v; f3 = f; d3 = d; end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_tbl(input int dut, input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t e;
      logic [3:0]  av;
      logic [31:0] ad;
      logic [1:0]  ap;
      logic [15:0] ag;
      drive(dut, tbl[i].v, tbl[i].f, tbl[i].d);
      sb.push_back(tbl[i]);
      step();
      drive(dut, 1'b0, 1'b0, 8'h00);
      case (dut)
        0:       begin av = ov0;         ad = od0;         ap = lp0; ag = gc0; end
        1:       begin av = ov1;         ad = od1;         ap = lp1; ag = gc1; end
        default: begin av = {1'b0, ov3}; ad = {8'h00, od3}; ap = lp3; ag = gc3; end
      endcase
      e = sb.pop_front();
      check($sformatf("%s[%0d].out_valid", tag, i), 32'(av), 32'(e.ev));
      check($sformatf("%s[%0d].out_data", tag, i), ad, e.ed);
      check($sformatf("%s[%0d].lane_ptr", tag, i), 32'(ap), 32'(e.ep));
      check($sformatf("%s[%0d].grp_cnt", tag, i), 32'(ag), 32'(e.eg));
    end
    tbl.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset for 2 cycles with valid words present on every instance.
    reset = 1'b1;
    drive(0, 1'b1, 1'b0, 8'hFF);
    drive(1, 1'b1, 1'b1, 8'hFF);
    drive(3, 1'b1, 1'b1, 8'hFF);
    step();
    step();
    check("rst.g1.out_valid", 32'(ov1), 32'h0);
    check("rst.g1.out_data", od1, 32'h0);
    check("rst.g1.lane_ptr", 32'(lp1), 32'h0);
    check("rst.g1.grp_cnt", 32'(gc1), 32'h0);
    check("rst.g0.out_valid", 32'(ov0), 32'h0);
    check("rst.g0.out_data", od0, 32'h0);
    check("rst.g0.lane_ptr", 32'(lp0), 32'h0);
    check("rst.g0.grp_cnt", 32'(gc0), 32'h0);
    check("rst.g3.out_valid", 32'(ov3), 32'h0);
    check("rst.g3.out_data", 32'(od3), 32'h0);
    check("rst.g3.lane_ptr", 32'(lp3), 32'h0);
    check("rst.g3.grp_cnt", 32'(gc3), 32'h0);
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00);
    drive(3, 1'b0, 1'b0, 8'h00);

    // Gather, 4 lanes: back-to-back group, gapped group, flushes.
    //  v  f  d      ev       ed             ptr  grp
    add(1, 0, 8'h11, 4'b0000, 32'h00000000, 2'd1, 16'd0);
    add(1, 0, 8'h22, 4'b0000, 32'h00000000, 2'd2, 16'd0);
    add(1, 0, 8'h33, 4'b0000, 32'h00000000, 2'd3, 16'd0);
    add(1, 0, 8'h44, 4'b1111, 32'h44332211, 2'd0, 16'd1);
    add(0, 0, 8'h00, 4'b0000, 32'h44332211, 2'd0, 16'd1);
    add(1, 0, 8'h11, 4'b0000, 32'h44332211, 2'd1, 16'd1);
    add(0, 0, 8'h00, 4'b0000, 32'h44332211, 2'd1, 16'd1);
    add(1, 0, 8'h22, 4'b0000, 32'h44332211, 2'd2, 16'd1);
    add(0, 0, 8'h00, 4'b0000, 32'h44332211, 2'd2, 16'd1);
    add(1, 0, 8'h33, 4'b0000, 32'h44332211, 2'd3, 16'd1);
    add(0, 0, 8'h00, 4'b0000, 32'h44332211, 2'd3, 16'd1);
    add(1, 0, 8'h44, 4'b1111, 32'h44332211, 2'd0, 16'd2);
    add(1, 0, 8'hA1, 4'b0000, 32'h44332211, 2'd1, 16'd2);
    add(1, 0, 8'hA2, 4'b0000, 32'h44332211, 2'd2, 16'd2);
    add(0, 1, 8'h00, 4'b0011, 32'h0000A2A1, 2'd0, 16'd3);
    add(0, 1, 8'h00, 4'b0000, 32'h0000A2A1, 2'd0, 16'd3);
    add(1, 0, 8'hB1, 4'b0000, 32'h0000A2A1, 2'd1, 16'd3);
    add(1, 1, 8'hB2, 4'b0011, 32'h0000B2B1, 2'd0, 16'd4);
    add(1, 0, 8'hC1, 4'b0000, 32'h0000B2B1, 2'd1, 16'd4);
    add(1, 0, 8'hC2, 4'b0000, 32'h0000B2B1, 2'd2, 16'd4);
    add(1, 0, 8'hC3, 4'b0000, 32'h0000B2B1, 2'd3, 16'd4);
    add(1, 1, 8'hC4, 4'b1111, 32'hC4C3C2C1, 2'd0, 16'd5);
    add(1, 1, 8'hD1, 4'b0001, 32'h000000D1, 2'd0, 16'd6);
    add(0, 0, 8'h00, 4'b0000, 32'h000000D1, 2'd0, 16'd6);
    run_tbl(1, "g1");

    // Reset in the middle of a partial group discards it.
    drive(1, 1'b1, 1'b0, 8'h11); step();
    check("seq.g1.stage1.out_valid", 32'(ov1), 32'h0);
    drive(1, 1'b1, 1'b0, 8'h22); step();
    check("seq.g1.stage2.out_valid", 32'(ov1), 32'h0);
    reset = 1'b1;
    drive(1, 1'b1, 1'b1, 8'h77); step();
    reset = 1'b0;
    check("seq.g1.rst.out_valid", 32'(ov1), 32'h0);
    check("seq.g1.rst.out_data", od1, 32'h0);
    check("seq.g1.rst.lane_ptr", 32'(lp1), 32'h0);
    check("seq.g1.rst.grp_cnt", 32'(gc1), 32'h0);
    drive(1, 1'b1, 1'b0, 8'h33); step();
    check("seq.g1.w33.out_valid", 32'(ov1), 32'h0);
    drive(1, 1'b1, 1'b0, 8'h44); step();
    check("seq.g1.w44.out_valid", 32'(ov1), 32'h0);
    drive(1, 1'b1, 1'b0, 8'h55); step();
    check("seq.g1.w55.out_valid", 32'(ov1), 32'h0);
    check("seq.g1.w55.lane_ptr", 32'(lp1), 32'd3);
    drive(1, 1'b1, 1'b0, 8'h66); step();
    drive(1, 1'b0, 1'b0, 8'h00);
    check("seq.g1.w66.out_valid", 32'(ov1), 32'hF);
    check("seq.g1.w66.out_data", od1, 32'h66554433);
    check("seq.g1.w66.lane_ptr", 32'(lp1), 32'd0);
    check("seq.g1.w66.grp_cnt", 32'(gc1), 32'd1);
    step();
    check("seq.g1.after.out_valid", 32'(ov1), 32'h0);

    // Stripe, 4 lanes: one-hot valid per word, flush ignored.
    add(1, 0, 8'h01, 4'b0001, 32'h00000001, 2'd1, 16'd0);
    add(1, 0, 8'h02, 4'b0010, 32'h00000201, 2'd2, 16'd0);
    add(1, 0, 8'h03, 4'b0100, 32'h00030201, 2'd3, 16'd0);
    add(1, 0, 8'h04, 4'b1000, 32'h04030201, 2'd0, 16'd1);
    add(1, 0, 8'h05, 4'b0001, 32'h04030205, 2'd1, 16'd1);
    add(0, 1, 8'h00, 4'b0000, 32'h04030205, 2'd1, 16'd1);
    add(1, 1, 8'h06, 4'b0010, 32'h04030605, 2'd2, 16'd1);
    add(0, 0, 8'h00, 4'b0000, 32'h04030605, 2'd2, 16'd1);
    run_tbl(0, "g0");

    // Gather, 3 lanes: pointer wraps 2 -> 0, partial flushes.
    add(1, 0, 8'h11, 4'b0000, 32'h00000000, 2'd1, 16'd0);
    add(1, 0, 8'h22, 4'b0000, 32'h00000000, 2'd2, 16'd0);
    add(1, 0, 8'h33, 4'b0111, 32'h00332211, 2'd0, 16'd1);
    add(1, 0, 8'h44, 4'b0000, 32'h00332211, 2'd1, 16'd1);
    add(1, 1, 8'h55, 4'b0011, 32'h00005544, 2'd0, 16'd2);
    add(1, 0, 8'h66, 4'b0000, 32'h00005544, 2'd1, 16'd2);
    add(1, 0, 8'h77, 4'b0000, 32'h00005544, 2'd2, 16'd2);
    add(1, 0, 8'h88, 4'b0111, 32'h00887766, 2'd0, 16'd3);
    add(1, 0, 8'h99, 4'b0000, 32'h00887766, 2'd1, 16'd3);
    add(1, 0, 8'hAA, 4'b0000, 32'h00887766, 2'd2, 16'd3);
    add(0, 1, 8'h00, 4'b0011, 32'h0000AA99, 2'd0, 16'd4);
    add(0, 0, 8'h00, 4'b0000, 32'h0000AA99, 2'd0, 16'd4);
    run_tbl(3, "g3");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
